// File: rtl/rv32i_pkg.sv
// Shared types and constants for the RV32I instruction fetch controller.
package rv32i_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_VEC_DEFAULT = 32'h0000_0000;

    // Fetch sequencer states: one post-reset cycle, then request / wait / hold.
    typedef enum logic [1:0] {
        S_RST  = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } fetch_state_t;

    // Instruction fetches are word aligned: drop the two low address bits.
    function automatic logic [XLEN-1:0] align_target(input logic [XLEN-1:0] raw);
        return {raw[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/rv32i_redirect_sel.sv
// Redirect source priority select (branch > JAL > JALR), target word
// alignment and detection of targets that were not word aligned in bit 1.
module rv32i_redirect_sel
    import rv32i_pkg::*;
(
    input  logic            br_take,
    input  logic [XLEN-1:0] br_target,
    input  logic            jal,
    input  logic [XLEN-1:0] jal_target,
    input  logic            jalr,
    input  logic [XLEN-1:0] jalr_target,
    output logic            redirect,
    output logic [XLEN-1:0] target,
    output logic            misalign
);

    logic [XLEN-1:0] raw_target;

    // Pick the highest-priority active source and derive the aligned target.
    always_comb begin
        // NOTE: every output gets a default before the if-chain so no path
        // leaves a value unassigned, which would otherwise infer a latch.
        raw_target = '0;
        if (br_take) begin
            raw_target = br_target;
        end else if (jal) begin
            raw_target = jal_target;
        end else if (jalr) begin
            raw_target = jalr_target;
        end
        redirect = br_take | jal | jalr;
        target   = align_target(raw_target);
        // Bit 0 is legitimately set by JALR arithmetic; only bit 1 is an error.
        misalign = redirect & raw_target[1];
    end

endmodule

// File: rtl/rv32i_fetch_ctrl.sv
// RV32I instruction fetch controller: issues one fetch at a time to the
// instruction memory, holds the returned instruction for decode and applies
// branch/jump redirects, discarding any fetch that a redirect made stale.
module rv32i_fetch_ctrl
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = RESET_VEC_DEFAULT,
    parameter int          XLEN      = 32
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            br_take,
    input  logic [XLEN-1:0] br_target,
    input  logic            jal,
    input  logic [XLEN-1:0] jal_target,
    input  logic            jalr,
    input  logic [XLEN-1:0] jalr_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr,
    input  logic            if_ready,
    output logic            misalign_err
);

    fetch_state_t    state;
    logic [XLEN-1:0] pc;        // next address to fetch
    logic [XLEN-1:0] fetch_pc;  // address of the fetch currently outstanding
    logic            drop;      // outstanding fetch was made stale by a redirect

    logic            redirect;
    logic [XLEN-1:0] target;
    logic            target_misalign;

    rv32i_redirect_sel u_redirect_sel (
        .br_take     (br_take),
        .br_target   (br_target),
        .jal         (jal),
        .jal_target  (jal_target),
        .jalr        (jalr),
        .jalr_target (jalr_target),
        .redirect    (redirect),
        .target      (target),
        .misalign    (target_misalign)
    );

    // Fetch sequencer: advances pc, tracks the outstanding fetch and holds data.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: all state here uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state        <= S_RST;
            pc           <= RESET_VEC;
            fetch_pc     <= '0;
            drop         <= 1'b0;
            if_pc        <= '0;
            if_instr     <= '0;
            misalign_err <= 1'b0;
        end else begin
            // Redirects are only acted on once the sequencer is running.
            misalign_err <= (state != S_RST) && target_misalign;
            case (state)
                S_RST: begin
                    state <= S_REQ;
                end
                S_REQ: begin
                    if (redirect) begin
                        // Memory tolerates an unacked address change; an acked
                        // fetch must still be collected and then thrown away.
                        pc <= target;
                        if (imem_ack) begin
                            drop  <= 1'b1;
                            state <= S_WAIT;
                        end
                    end else if (imem_ack) begin
                        fetch_pc <= pc;
                        pc       <= pc + XLEN'(4);
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (drop || redirect) begin
                            drop  <= 1'b0;
                            state <= S_REQ;
                            if (redirect) begin
                                pc <= target;
                            end
                        end else begin
                            if_instr <= imem_rdata;
                            if_pc    <= fetch_pc;
                            state    <= S_HOLD;
                        end
                    end else if (redirect) begin
                        pc   <= target;
                        drop <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (redirect) begin
                        pc    <= target;
                        state <= S_REQ;
                    end else if (if_ready) begin
                        state <= S_REQ;
                    end
                end
                default: begin
                    state <= S_RST;
                end
            endcase
        end
    end

    assign imem_req  = (state == S_REQ);
    assign imem_addr = pc;
    // A redirect in the hold cycle kills the instruction before decode sees it.
    assign if_valid  = (state == S_HOLD) && !redirect;

endmodule
